// File: rtl/int_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: CLINT flag bus, config map, CTRL bits, FSM states.
// Combinational definitions only; no timing or backpressure of its own.
package int_arbiter_pkg;

  localparam int INT_BUS = 8;
  localparam logic [INT_BUS-1:0] INT_NONE = '0;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_EDGE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int CTRL_RR_EN = 0;
  localparam int CTRL_GIE   = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } arb_state_e;

  // Packed so that a 16'() cast lands gie on bit 1 and rr_en on bit 0.
  typedef struct packed {
    logic gie;
    logic rr_en;
  } ctrl_t;

endpackage

// File: rtl/int_arbiter_if.sv
// Config bus plus CLINT handshake (int_flag held until int_ack, int_eoi closes service).
// master = host/CLINT side, slave = arbiter side.
interface int_arbiter_if;

  logic                                 cfg_we;
  logic [1:0]                           cfg_addr;
  logic [15:0]                          cfg_wdata;
  logic [15:0]                          cfg_rdata;
  logic [int_arbiter_pkg::INT_BUS-1:0]  int_flag;
  logic                                 int_ack;
  logic                                 int_eoi;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
    input  cfg_rdata, int_flag
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
    output cfg_rdata, int_flag
  );

endinterface

// File: rtl/int_prio_pick.sv
// Combinational priority picker: first set request at or after start (wrapping) when rr_en,
// otherwise the lowest set request. Zero latency, no backpressure.
module int_prio_pick #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic [NSRC-1:0] req_i,
  input  logic [IDW-1:0]  start_i,
  input  logic            rr_en_i,
  output logic            vld_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW-1:0] base;

  assign base = rr_en_i ? start_i : '0;

  // Walk offsets from the far end down so the nearest hit to base is written last.
  // The IDW-bit add wraps modulo NSRC because NSRC is a power of two.
  always_comb begin
    logic [IDW-1:0] cand;
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      cand = base + k[IDW-1:0];
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge/level pending capture, fixed or round-robin pick, IDLE/REQ/SERVICE handshake.
// Edge to int_flag is 2 cycles; int_flag is held until int_ack, and no new request until int_eoi.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  int_arbiter_if.slave    bus,
  output logic            irq_busy,
  output logic [IDW-1:0]  irq_id
);

  logic [NSRC-1:0]    enable_q, enable_d;
  logic [NSRC-1:0]    edge_q, edge_d;
  logic [NSRC-1:0]    pending_q, pending_d;
  logic [NSRC-1:0]    hist_q;
  ctrl_t              ctrl_q, ctrl_d;
  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [INT_BUS-1:0] flag_q, flag_d;

  logic [NSRC-1:0]    rise;
  logic [NSRC-1:0]    sw_clr;
  logic [NSRC-1:0]    ack_clr;
  logic [NSRC-1:0]    cand;
  logic [IDW-1:0]     rr_start;
  logic               pick_vld;
  logic [IDW-1:0]     pick_idx;
  logic               unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata[15:NSRC];

  // Config register writes; a PENDING write is a write-one-to-clear mask.
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    ctrl_d   = ctrl_q;
    sw_clr   = '0;
    if (bus.cfg_we) begin
      case (bus.cfg_addr)
        ADDR_ENABLE:  enable_d = bus.cfg_wdata[NSRC-1:0];
        ADDR_EDGE:    edge_d   = bus.cfg_wdata[NSRC-1:0];
        ADDR_PENDING: sw_clr   = bus.cfg_wdata[NSRC-1:0];
        ADDR_CTRL: begin
          ctrl_d.gie   = bus.cfg_wdata[CTRL_GIE];
          ctrl_d.rr_en = bus.cfg_wdata[CTRL_RR_EN];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      ADDR_ENABLE:  bus.cfg_rdata = 16'(enable_q);
      ADDR_EDGE:    bus.cfg_rdata = 16'(edge_q);
      ADDR_PENDING: bus.cfg_rdata = 16'(pending_q);
      ADDR_CTRL:    bus.cfg_rdata = 16'(ctrl_q);
      default:      bus.cfg_rdata = '0;
    endcase
  end

  // Edge bits: a fresh rise beats any clear in the same cycle. Level bits track the delayed line.
  assign rise      = irq_src & ~hist_q;
  assign pending_d = (edge_q & (rise | (pending_q & ~(sw_clr | ack_clr))))
                   | (~edge_q & irq_src);

  assign cand     = pending_q & enable_q & {NSRC{ctrl_q.gie}};
  assign rr_start = last_q + IDW'(1);

  int_prio_pick #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_pick (
    .req_i   (cand),
    .start_i (rr_start),
    .rr_en_i (ctrl_q.rr_en),
    .vld_o   (pick_vld),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    flag_d  = flag_q;
    ack_clr = '0;
    case (state_q)
      ST_IDLE: begin
        flag_d = INT_NONE;
        if (pick_vld) begin
          id_d    = pick_idx;
          flag_d  = INT_BUS'(pick_idx) + INT_BUS'(1);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A withdrawn request takes precedence over an ack arriving in the same cycle.
        if (!cand[id_q]) begin
          flag_d  = INT_NONE;
          state_d = ST_IDLE;
        end else if (bus.int_ack) begin
          ack_clr = edge_q & (NSRC'(1) << id_q);
          last_d  = id_q;
          flag_d  = INT_NONE;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        flag_d = INT_NONE;
        if (bus.int_eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        flag_d  = INT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q  <= '0;
      edge_q    <= '0;
      pending_q <= '0;
      ctrl_q    <= '0;
      hist_q    <= '0;
      state_q   <= ST_IDLE;
      id_q      <= '0;
      last_q    <= IDW'(NSRC - 1);
      flag_q    <= INT_NONE;
    end else begin
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      ctrl_q    <= ctrl_d;
      hist_q    <= irq_src;
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      flag_q    <= flag_d;
    end
  end

  assign bus.int_flag = flag_q;
  assign irq_busy     = (state_q == ST_REQ) || (state_q == ST_SERVICE);
  assign irq_id       = id_q;

endmodule

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter NSRC, default 8, SHALL set the number of interrupt sources; only 8 is supported.
REQ-002 Parameter IDW, default 3, SHALL set the source-index width, log2(NSRC).
REQ-003 Port clk, input, 1, SHALL be the single clock; one clock; reset is synchronous and active-high.
REQ-004 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Port irq_src, input, NSRC, SHALL carry the raw interrupt lines, synchronous to clk.
REQ-006 Port cfg_we, input, 1, SHALL be the config write strobe.
REQ-007 Port cfg_addr, input, 2, SHALL select the config register (0 ENABLE, 1 EDGE, 2 PENDING, 3 CTRL).
REQ-008 Port cfg_wdata, input, 16, SHALL carry the config write data.
REQ-009 Port cfg_rdata, output, 16, SHALL be the combinational read of cfg_addr, zero-extended.
REQ-010 Port int_flag, output, `INT_BUS (8), SHALL drive the CLINT int_flag input: `INT_NONE (0) when idle, winner index+1 when requesting.
REQ-011 Port int_ack, input, 1, SHALL be a 1-cycle pulse, asserted when CLINT accepts an interrupt.
REQ-012 Port int_eoi, input, 1, SHALL be a 1-cycle pulse, asserted on interrupt return (MRET).
REQ-013 Port irq_busy, output, 1, SHALL be high in the REQ and SERVICE states.
REQ-014 Port irq_id, output, IDW, SHALL hold the latched winner index.

Function
REQ-015 The ENABLE[7:0] and EDGE[7:0] registers SHALL be read/write; EDGE bit=1 selects rising-edge mode and 0 selects level mode.
REQ-016 CTRL SHALL be read/write with bit0 = rr_en (round-robin) and bit1 = gie (arbiter global enable).
REQ-017 PENDING SHALL be read-only; a write to PENDING SHALL clear each bit written as 1.
REQ-018 In edge mode, a pending bit SHALL set on the cycle after irq_src rises (0 to 1, against a registered copy of the previous value).
REQ-019 In level mode, a pending bit SHALL equal the registered irq_src.
REQ-020 If an edge set and a clear (software or ack) hit the same bit in the same cycle, the set SHALL win.
REQ-021 The candidate set SHALL be PENDING & ENABLE, and candidates SHALL be considered only when gie=1.
REQ-022 With rr_en=0, the lowest candidate index SHALL win.
REQ-023 With rr_en=1, the search SHALL start at last_grant+1 and wrap modulo NSRC; last_grant SHALL reset to NSRC-1.
REQ-024 The state machine SHALL have three states: IDLE, REQ and SERVICE.
REQ-025 In IDLE with a candidate present, the arbiter SHALL latch the winner into irq_id and go to REQ; int_flag SHALL be registered and equal irq_id+1 from the next cycle.
REQ-026 In REQ, int_flag SHALL be held stable until int_ack; irq_id SHALL NOT change, even if a higher-priority source arrives.
REQ-027 In REQ on int_ack, the arbiter SHALL clear the winner's pending bit (edge mode only), update last_grant, drive int_flag to 0 and go to SERVICE.
REQ-028 In REQ, if the winner's pending or enable bit drops, or gie drops, before int_ack, the arbiter SHALL return to IDLE and drive int_flag to 0 on the next cycle.
REQ-029 In SERVICE, the arbiter SHALL issue no new request; int_eoi SHALL return it to IDLE.
REQ-030 Latency: an edge at cycle N SHALL set pending at N+1 and int_flag at N+2 when idle.
REQ-031 int_ack outside REQ and int_eoi outside SERVICE SHALL be ignored.
REQ-032 If int_ack and int_eoi arrive in the same cycle, only the pulse valid for the current state SHALL apply.

Reset
REQ-033 On rst=1 at a clk edge, the following SHALL be zeroed: ENABLE, EDGE, PENDING, CTRL, the irq_src history register, int_flag and irq_id.
REQ-034 On the same reset, last_grant SHALL go to NSRC-1, the state to IDLE, and irq_busy to 0.
REQ-035 Reset mid-REQ or mid-SERVICE SHALL abandon the request silently.

Structure
REQ-036 `INT_BUS, `INT_NONE, the register addresses and the CTRL bit positions SHALL live in the shared para.v.
REQ-037 The round-robin/fixed priority picker SHALL be the sub-module int_prio_pick (combinational; inputs req, start index, rr_en; outputs valid, index).

Verification
REQ-038 The bench SHALL cover: ENABLE=0x01, EDGE=0x01, CTRL=0x2, pulse irq_src[0] at cycle N -> int_flag=1 at N+2; int_ack -> int_flag=0, PENDING=0, irq_busy=1; int_eoi -> IDLE.
REQ-039 The bench SHALL cover: ENABLE=0xFF, level mode, CTRL=0x2, irq_src=0x28 -> int_flag=4 (source 3 wins).
REQ-040 The bench SHALL cover: CTRL=0x3, irq_src=0x05 held, level mode, three ack/eoi rounds -> int_flag sequence 1, 3, 1.
REQ-041 The bench SHALL cover: in REQ for source 2, write PENDING=0x04 -> int_flag=0 next cycle, state IDLE, int_ack ignored.
REQ-042 The bench SHALL cover: an edge on source 1 in the same cycle as a PENDING write of 0x02 -> PENDING bit1 = 1.
REQ-043 The bench SHALL cover: rst=1 during SERVICE -> all outputs 0 next cycle, and an int_eoi after release is ignored.
